// File: rtl/arith_sequencer.sv
// Single-transaction sequencer in front of a pipelined arithmetic unit: it accepts a
// command, optionally pulses the unit's reset, waits out the unit latency, and returns a tagged result.
module arith_sequencer #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_clr,
    output logic        au_reset,
    output logic [15:0] au_data_1,
    output logic [15:0] au_data_2,
    output logic [1:0]  au_op_sel,
    input  logic [15:0] au_data_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic [7:0]  rsp_tag,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic [7:0] tag_cnt;

    assign cmd_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_tag   = tag_cnt;

    // NOTE: every register here uses non-blocking assignment so all of them see
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            tag_cnt   <= '0;
            au_reset  <= 1'b0;
            au_data_1 <= '0;
            au_data_2 <= '0;
            au_op_sel <= '0;
            rsp_data  <= '0;
            rsp_op    <= '0;
        end else begin
            au_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        au_data_1 <= cmd_a;
                        au_data_2 <= cmd_b;
                        au_op_sel <= cmd_op;
                        if (cmd_clr) begin
                            state    <= CLR;
                            au_reset <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                CLR: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    // Capture one edge after the count runs out: the operands
                    // themselves took an edge to reach the unit.
                    if (wait_cnt == 4'd0) begin
                        rsp_data <= au_data_out;
                        rsp_op   <= au_op_sel;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state   <= IDLE;
                        tag_cnt <= tag_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
